tx_engine: RTL and testbench
============================

Name: tx_engine

Overview:
- UART transmit engine; the transmit counterpart of the UART receive path in the same codebase.
- Accepts a byte from the processor-side port on a load strobe and serialises it LSB first on tx as: 1 start bit, 7 or 8 data bits, optional parity bit, 1 stop bit.
- Bit period is set by the same 19-bit baud constant k that the receive engine uses.
- TXRDY reports when a new byte may be written.

Parameters:
- KW, 19, width of baud constant k.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  one-cycle write strobe; accepted only while TXRDY=1
- out_port  input  8  byte to transmit; bit 7 ignored when eight=0
- eight  input  1  1 = 8 data bits, 0 = 7 data bits
- pen  input  1  parity enable
- even  input  1  1 = even parity, 0 = odd parity
- k  input  KW  bit time = k+1 clk cycles
- tx  output  1  serial line, idle high
- TXRDY  output  1  1 = transmitter idle, can accept load

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst=1:
  - tx=1, TXRDY=1.
  - Shift register all ones; bit counter and bit-time counter = 0; doit=0.
  - Reset mid-frame aborts the frame immediately, with no glitch low on tx.
- Accept:
  - On the rising edge where load=1 and TXRDY=1, latch out_port, eight, pen, even and k into frame registers.
  - Load the 11-bit shift register; set doit=1; TXRDY=0 from the next cycle.
  - load while TXRDY=0 is ignored: no state change, no error flag.
- Latency: tx drives the start bit (0) in the first cycle after the accepting edge.
- Shift register contents (bit0 is sent first; tx = sr[0]):
  - 8 data, parity:    {1, p, d[7:0], 0}
  - 8 data, no parity: {1, 1, d[7:0], 0}
  - 7 data, parity:    {1, 1, p, d[6:0], 0}
  - 7 data, no parity: {1, 1, 1, d[6:0], 0}
- Parity: p = ^data bits when even=1, p = ~^data bits when even=0, using 7 or 8 data bits per eight. This matches the receiver's parity check.
- Frame length N (bits including start and stop):
  - 9 for 7N, 10 for 7P, 10 for 8N, 11 for 8P.
- Bit timing:
  - Bit-time counter btc runs 0..k while doit=1.
  - btu = (btc == k_latched); on btu, btc returns to 0.
  - Each bit is held exactly k+1 cycles. k=0 gives 1 cycle per bit.
- Shifting:
  - On btu, sr shifts right with 1 filled at bit 10.
  - Bit counter increments on btu.
- Completion:
  - When the bit counter reaches N on a btu, clear doit, clear the bit counter and btc, and set TXRDY=1 on that same edge.
  - tx is then 1 (stop level retained).
  - Total busy time is N*(k+1) cycles from the start bit to TXRDY=1.
- Back-to-back: a load in the first cycle TXRDY=1 is accepted. The start bit follows the stop bit with zero idle cycles.
- Input stability: eight, pen, even and k may change at any time without affecting a frame in flight, since all are latched at accept.
- States: IDLE (doit=0, TXRDY=1) -> SEND (doit=1) -> IDLE. No other states. Any illegal encoding returns to IDLE.

Decomposition:
- Shared package (uart_pkg):
  - KW=19.
  - Frame-length constants FRAME_7N=9, FRAME_7P=10, FRAME_8N=10, FRAME_8P=11.
  - Function frame_len(eight, pen), also to be used by rx_engine.
- Sub-module tx_bit_timer: KW-bit counter with inputs run and k, output btu. Reusable as the basis of a receive-side timer.

Test Plan:
- k=3, eight=1, pen=0, load 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 clk; TXRDY low for exactly 40 cycles.
- k=3, 8P even, load 0xA5 (four ones) -> parity bit 0; frame 0,1,0,1,0,0,1,0,1,0,1; TXRDY low for 44 cycles.
- k=1, 7P odd, load 0xC1 (data 0x41, two ones) -> parity bit 1; bit 7 of out_port not sent; 10 bits of 2 clk each.
- load 0x12 accepted, load 0xFF pulsed 5 cycles later -> second load ignored; only 0x12 sent; TXRDY stays 0 until the frame ends.
- Assert rst during data bit 3 -> tx=1 and TXRDY=1 asynchronously; the next load sends a clean full frame.
- Back-to-back 0x00 then 0xFF with load on the first TXRDY=1 cycle; loop tx into rx_engine with the same k, eight, pen, even -> both bytes received; PERR, FERR and OVF stay 0 when clr is pulsed between bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constant width, frame lengths and state encoding.
package uart_pkg;

  localparam int KW       = 19;
  localparam int FRAME_7N = 9;
  localparam int FRAME_7P = 10;
  localparam int FRAME_8N = 10;
  localparam int FRAME_8P = 11;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } tx_state_e;

  // Bits per frame, including start and stop bits.
  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    logic [3:0] n;
    case ({eight, pen})
      2'b11:   n = 4'(FRAME_8P);
      2'b10:   n = 4'(FRAME_8N);
      2'b01:   n = 4'(FRAME_7P);
      default: n = 4'(FRAME_7N);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time counter: while run=1, counts 0..k and pulses btu on the last count.
// btu is combinational from the counter state; no backpressure.
module tx_bit_timer #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [KW-1:0] k,
  output logic          btu
);

  logic [KW-1:0] btc_q, btc_d;

  assign btu = run && (btc_q == k);

  always_comb begin
    btc_d = btc_q;
    if (!run || btu) begin
      btc_d = '0;
    end else begin
      btc_d = btc_q + KW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btc_q <= '0;
    end else begin
      btc_q <= btc_d;
    end
  end

endmodule

// File: rtl/tx_engine.sv
// UART transmitter: start bit on tx one cycle after an accepted load, then N bits of k+1 cycles each.
// load is only honoured while TXRDY=1; loads while busy are dropped silently.
module tx_engine #(
  parameter int KW = uart_pkg::KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [7:0]    out_port,
  input  logic          eight,
  input  logic          pen,
  input  logic          even,
  input  logic [KW-1:0] k,
  output logic          tx,
  output logic          TXRDY
);

  import uart_pkg::*;

  tx_state_e     state_q, state_d;
  logic [10:0]   sr_q, sr_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    n_q, n_d;
  logic [KW-1:0] k_q, k_d;
  logic          btu, accept, done, doit;
  logic [7:0]    data;
  logic          par;
  logic [10:0]   sr_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (btu && (bit_cnt_q == n_q - 4'd1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign doit  = (state_q == SEND);
  assign TXRDY = (state_q == IDLE);
  assign tx    = sr_q[0];

  // Bit 7 is forced to zero in 7-bit mode so the same reduction gives 7-bit parity.
  always_comb begin
    data = eight ? out_port : {1'b0, out_port[6:0]};
    par  = even ? ^data : ~^data;
    case ({eight, pen})
      2'b11:   sr_load = {1'b1, par, out_port, 1'b0};
      2'b10:   sr_load = {2'b11, out_port, 1'b0};
      2'b01:   sr_load = {2'b11, par, out_port[6:0], 1'b0};
      default: sr_load = {3'b111, out_port[6:0], 1'b0};
    endcase
  end

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    n_d       = n_q;
    k_d       = k_q;
    if (accept) begin
      sr_d      = sr_load;
      bit_cnt_d = '0;
      n_d       = frame_len(eight, pen);
      k_d       = k;
    end else if (btu) begin
      sr_d      = {1'b1, sr_q[10:1]};
      bit_cnt_d = done ? 4'd0 : bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '1;
      bit_cnt_q <= '0;
      n_q       <= '0;
      k_q       <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      n_q       <= n_d;
      k_q       <= k_d;
    end
  end

  tx_bit_timer #(
    .KW(KW)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .run (doit),
    .k   (k_q),
    .btu (btu)
  );

endmodule

// File: tb/tb_tx_engine.sv
// Directed bench for tx_engine: per-cycle tx traces against hand-built frames.
module tb_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  out_port;
  logic        eight;
  logic        pen;
  logic        even;
  logic [18:0] k;
  logic        tx;
  logic        TXRDY;

  int checks = 0;
  int errors = 0;

  logic [127:0] trace;
  int           busy;

  tx_engine dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .even     (even),
    .k        (k),
    .tx       (tx),
    .TXRDY    (TXRDY)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Records tx on every negedge while TXRDY=0; returns on the first negedge with TXRDY=1.
  task automatic capture();
    busy  = 0;
    trace = '0;
    @(negedge clk);
    while (TXRDY === 1'b0 && busy < 200) begin
      if (busy < 128) trace[busy] = tx;
      busy++;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] expand(input logic [10:0] bits, input int n, input int kk);
    logic [127:0] e;
    e = '0;
    for (int c = 0; c < n * (kk + 1); c++) e[c] = bits[c / (kk + 1)];
    return e;
  endfunction

  task automatic do_load(input logic [7:0] d, input logic e8, input logic pe,
                         input logic ev, input int kk);
    @(negedge clk);
    out_port = d;
    eight    = e8;
    pen      = pe;
    even     = ev;
    k        = 19'(kk);
    load     = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; out_port = '0; eight = 1'b1; pen = 1'b0; even = 1'b1; k = '0;
    #12;
    checks++;
    if (tx !== 1'b1 || TXRDY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tx=%b TXRDY=%b, required tx=1 TXRDY=1", tx, TXRDY);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || TXRDY !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b TXRDY=%b, required tx=1 TXRDY=1", tx, TXRDY);
    end
  endtask

  task automatic test_8n();
    do_load(8'h55, 1'b1, 1'b0, 1'b1, 3);
    capture();
    checks++;
    if (busy !== 40) begin
      errors++;
      $display("FAIL 8n_busy: %0d cycles, required 40", busy);
    end
    checks++;
    if (trace !== expand(11'h2AA, 10, 3)) begin
      errors++;
      $display("FAIL 8n_trace: got %h, required %h", trace, expand(11'h2AA, 10, 3));
    end
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL 8n_stop_level: tx=%b, required 1", tx);
    end
  endtask

  task automatic test_8p_even();
    do_load(8'hA5, 1'b1, 1'b1, 1'b1, 3);
    capture();
    checks++;
    if (busy !== 44) begin
      errors++;
      $display("FAIL 8p_busy: %0d cycles, required 44", busy);
    end
    checks++;
    if (trace !== expand(11'h54A, 11, 3)) begin
      errors++;
      $display("FAIL 8p_trace: got %h, required %h", trace, expand(11'h54A, 11, 3));
    end
  endtask

  task automatic test_7p_odd();
    do_load(8'hC1, 1'b0, 1'b1, 1'b0, 1);
    capture();
    checks++;
    if (busy !== 20) begin
      errors++;
      $display("FAIL 7p_busy: %0d cycles, required 20", busy);
    end
    checks++;
    if (trace !== expand(11'h382, 10, 1)) begin
      errors++;
      $display("FAIL 7p_trace: got %h, required %h", trace, expand(11'h382, 10, 1));
    end
  endtask

  task automatic test_k0_7n();
    do_load(8'h3C, 1'b0, 1'b0, 1'b1, 0);
    capture();
    checks++;
    if (busy !== 9) begin
      errors++;
      $display("FAIL k0_busy: %0d cycles, required 9", busy);
    end
    checks++;
    if (trace !== expand(11'h178, 9, 0)) begin
      errors++;
      $display("FAIL k0_trace: got %h, required %h", trace, expand(11'h178, 9, 0));
    end
  endtask

  task automatic test_ignore_load();
    do_load(8'h12, 1'b1, 1'b0, 1'b1, 3);
    fork
      capture();
      begin
        repeat (5) @(negedge clk);
        out_port = 8'hFF; load = 1'b1; k = 19'd0; eight = 1'b0; pen = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join
    checks++;
    if (busy !== 40) begin
      errors++;
      $display("FAIL ignore_busy: %0d cycles, required 40", busy);
    end
    checks++;
    if (trace !== expand(11'h224, 10, 3)) begin
      errors++;
      $display("FAIL ignore_trace: got %h, required %h", trace, expand(11'h224, 10, 3));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (TXRDY !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_refire: tx=%b TXRDY=%b, required tx=1 TXRDY=1", tx, TXRDY);
    end
  endtask

  task automatic test_reset_midframe();
    do_load(8'h55, 1'b1, 1'b0, 1'b1, 3);
    repeat (18) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || TXRDY !== 1'b0) begin
      errors++;
      $display("FAIL midframe_bit3: tx=%b TXRDY=%b, required tx=0 TXRDY=0", tx, TXRDY);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || TXRDY !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: tx=%b TXRDY=%b, required tx=1 TXRDY=1", tx, TXRDY);
    end
    @(negedge clk) rst = 1'b0;
    do_load(8'h55, 1'b1, 1'b0, 1'b1, 3);
    capture();
    checks++;
    if (busy !== 40 || trace !== expand(11'h2AA, 10, 3)) begin
      errors++;
      $display("FAIL post_reset_frame: busy=%0d trace=%h, required busy=40 trace=%h",
               busy, trace, expand(11'h2AA, 10, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx0, rx1;
    do_load(8'h00, 1'b1, 1'b1, 1'b1, 1);
    capture();
    for (int b = 0; b < 8; b++) rx0[b] = trace[(b + 1) * 2];
    checks++;
    if (busy !== 22 || trace !== expand(11'h400, 11, 1)) begin
      errors++;
      $display("FAIL b2b_first: busy=%0d trace=%h, required busy=22 trace=%h",
               busy, trace, expand(11'h400, 11, 1));
    end
    checks++;
    if (tx !== 1'b1 || TXRDY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: tx=%b TXRDY=%b, required tx=1 TXRDY=1", tx, TXRDY);
    end
    out_port = 8'hFF;
    load     = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    capture();
    for (int b = 0; b < 8; b++) rx1[b] = trace[(b + 1) * 2];
    checks++;
    if (busy !== 22 || trace !== expand(11'h5FE, 11, 1)) begin
      errors++;
      $display("FAIL b2b_second: busy=%0d trace=%h, required busy=22 trace=%h",
               busy, trace, expand(11'h5FE, 11, 1));
    end
    checks++;
    if (rx0 !== 8'h00 || rx1 !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_decode: got %h %h, required 00 ff", rx0, rx1);
    end
    checks++;
    if (trace[18] !== 1'b0 || trace[20] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_parity_stop: parity=%b stop=%b, required parity=0 stop=1",
               trace[18], trace[20]);
    end
  endtask

  initial begin
    test_reset();
    test_8n();
    test_8p_even();
    test_7p_odd();
    test_k0_7n();
    test_ignore_load();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
